// File: rtl/trng_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trng_bridge_pkg                                                      |
// | Shared constants and helpers for the TRNG read bridge.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package trng_bridge_pkg;

   localparam int MODE_PULSE  = 0;
   localparam int MODE_STREAM = 1;
   localparam int DROP_CNT_W  = 16;

   // Occupancy needs one extra bit so that "completely full" is representable.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/trng_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trng_sync_fifo                                                       |
// | Single-clock show-ahead FIFO with explicit occupancy counter.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trng_sync_fifo
   import trng_bridge_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = 16
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [W-1:0]                  wr_data,
   input  logic                          rd_en,
   output logic [W-1:0]                  rd_data,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          full,
   output logic                          empty
);

   localparam int c_AW    = $clog2(DEPTH);
   localparam int c_LVL_W = level_width(DEPTH);

   logic [W-1:0]       r_mem [DEPTH];
   logic [c_AW-1:0]    r_wr_ptr;
   logic [c_AW-1:0]    r_rd_ptr;
   logic [c_LVL_W-1:0] r_level;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign rd_data = r_mem[r_rd_ptr];
   assign level   = r_level;
   assign full    = (r_level == c_LVL_W'(DEPTH));
   assign empty   = (r_level == '0);

endmodule
`default_nettype wire

// File: rtl/trng_read_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trng_read_bridge                                                     |
// | Packs entropy words, buffers them and serves GPIO pulses or a stream.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trng_read_bridge
   import trng_bridge_pkg::*;
#(
   parameter int IN_W         = 32,
   parameter int OUT_W        = 32,
   parameter int DEPTH        = 16,
   parameter int MODE         = 0,
   parameter int DROP_ON_FULL = 1,
   parameter int AF_THRESH    = 12
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          in_valid,
   input  logic [IN_W-1:0]               in_data,
   output logic                          in_ready,
   input  logic                          read_req,
   input  logic                          out_ready,
   output logic [OUT_W-1:0]              out_data,
   output logic                          out_valid,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          empty,
   output logic                          almost_full,
   output logic [DROP_CNT_W-1:0]         drop_cnt,
   output logic                          underflow,
   input  logic                          clear_stats
);

   localparam int c_RATIO = OUT_W / IN_W;
   localparam int c_CNT_W = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
   localparam int c_LVL_W = level_width(DEPTH);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_RATIO - 1);

   logic [c_CNT_W-1:0]    r_cnt;
   logic [OUT_W-1:0]      r_slots;
   logic                  r_req_d;
   logic [OUT_W-1:0]      r_out_data;
   logic                  r_out_valid;
   logic [DROP_CNT_W-1:0] r_drop_cnt;
   logic                  r_underflow;

   logic                  w_last;
   logic                  w_rdy;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_pop;
   logic                  w_edge;
   logic [OUT_W-1:0]      w_word;
   logic [OUT_W-1:0]      w_head;
   logic                  w_full;
   logic                  w_empty;
   logic [c_LVL_W-1:0]    w_level;

   assign w_last   = (r_cnt == c_LAST);
   assign w_rdy    = (DROP_ON_FULL != 0) ? enable : (enable & ~(w_last & w_full));
   assign in_ready = ~rst & w_rdy;
   assign w_accept = in_valid & in_ready;
   assign w_push   = w_accept & w_last & ~w_full;
   assign w_drop   = w_accept & w_last & w_full;
   assign w_edge   = read_req & ~r_req_d;

   // The completing input goes straight into the FIFO alongside the held slots.
   always_comb begin
      w_word = r_slots;
      w_word[r_cnt*IN_W +: IN_W] = in_data;
   end

   always_comb begin
      w_pop = 1'b0;
      if (MODE == MODE_STREAM) begin
         w_pop = (~r_out_valid | out_ready) & ~w_empty;
      end else begin
         w_pop = w_edge & ~w_empty;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_slots <= '0;
      end else if (w_accept) begin
         r_slots[r_cnt*IN_W +: IN_W] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_d <= 1'b0;
      end else begin
         r_req_d <= read_req;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else if (MODE == MODE_STREAM) begin
         if (w_pop) begin
            r_out_data  <= w_head;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end else begin
         r_out_valid <= w_pop;
         if (w_pop) begin
            r_out_data <= w_head;
         end
      end
   end

   // Clearing takes priority over a coincident drop or underflow event.
   always_ff @(posedge clk) begin
      if (rst || clear_stats) begin
         r_drop_cnt  <= '0;
         r_underflow <= 1'b0;
      end else begin
         if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
         if ((MODE != MODE_STREAM) && w_edge && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   trng_sync_fifo #(
      .W     (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_push),
      .wr_data (w_word),
      .rd_en   (w_pop),
      .rd_data (w_head),
      .level   (w_level),
      .full    (w_full),
      .empty   (w_empty)
   );

   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign level       = w_level;
   assign empty       = w_empty;
   assign almost_full = (w_level >= c_LVL_W'(AF_THRESH));
   assign drop_cnt    = r_drop_cnt;
   assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: doc/trng_read_bridge.md
Name: trng_read_bridge

Overview:
Parametrised buffer between the TRNG entropy source and the PS-side reader.
- Packs IN_W-bit entropy words into OUT_W-bit words and buffers them in a DEPTH-entry synchronous FIFO.
- Delivers words either by edge-triggered read pulses from Zynq GPIO, or by a valid/ready stream toward an AXI-Stream adapter.
- Adds a configurable full policy (drop or backpressure), fill-level reporting and error statistics.

Parameters:
IN_W, 32, entropy input width in bits.
OUT_W, 32, output word width; must be an integer multiple of IN_W (RATIO = OUT_W/IN_W, 1..8).
DEPTH, 16, FIFO entries; power of 2, minimum 2.
MODE, 0, 0 = pulse mode (GPIO read_req edge), 1 = stream mode (out_valid/out_ready).
DROP_ON_FULL, 1, 1 = discard completed words when FIFO full; 0 = backpressure via in_ready.
AF_THRESH, 12, almost_full asserted when level >= AF_THRESH; range 1..DEPTH.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  accept entropy; low flushes packer
in_valid  in  1  entropy word valid
in_data  in  IN_W  entropy word
in_ready  out  1  entropy word accepted when in_valid & in_ready
read_req  in  1  pulse mode: pop on rising edge; ignored in stream mode
out_ready  in  1  stream mode: sink ready; ignored in pulse mode
out_data  out  OUT_W  registered output word
out_valid  out  1  pulse mode: 1-cycle strobe; stream mode: holding valid data
level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
drop_cnt  out  16  saturating count of discarded packed words
underflow  out  1  sticky: read edge seen while FIFO empty
clear_stats  in  1  synchronous clear of drop_cnt and underflow

Behaviour:
- Reset values: out_data 0, out_valid 0, level 0, empty 1, almost_full 0, drop_cnt 0, underflow 0, packer count 0, read_req delay reg 0. in_ready is 0 while rst is high.
- Packer:
  - Holds a count 0..RATIO-1. Each accepted input fills slot [count*IN_W +: IN_W], so the first word lands in the LSBs.
  - On acceptance of the last slot, the assembled word (current in_data combined with held slots) is written to the FIFO that cycle. There is no extra latency stage.
- Full policy:
  - FIFO full is the registered level == DEPTH.
  - DROP_ON_FULL=1: in_ready = enable. A completed word arriving while full is discarded, and drop_cnt increments, saturating at 16'hFFFF.
  - DROP_ON_FULL=0: in_ready = enable & ~(count == RATIO-1 & full). No drops occur.
- enable low: in_ready is 0 and packer count clears next cycle; the partial word is discarded and not counted. FIFO contents are retained.
- Pulse mode (MODE=0):
  - read_req is registered; a pop occurs on read_req & ~read_req_d.
  - Pop with FIFO non-empty: out_data is loaded with the head word and out_valid pulses high for exactly 1 cycle, on the cycle after the edge.
  - Edge with FIFO empty: no pop, out_valid stays 0, out_data holds, underflow is set.
  - out_data holds its last value between reads.
- Stream mode (MODE=1):
  - The output register loads the FIFO head when (~out_valid | out_ready) & ~empty, and out_valid is set.
  - out_valid clears when out_ready is high and the FIFO is empty.
  - out_data must be stable while out_valid & ~out_ready. Sustained throughput is 1 word per cycle.
  - Latency from FIFO write at edge n to out_valid is edge n+1.
- Simultaneous push and pop at any level leaves level unchanged. Push while full never occurs (policy above); pop while empty never occurs.
- FIFO pointers wrap modulo DEPTH. level is derived from a separate counter, not pointer difference.
- clear_stats: drop_cnt and underflow clear next cycle. If clear_stats coincides with a drop or underflow event, the clear wins.
- rst mid-operation: all state returns to reset values next edge; buffered words are lost.

Decomposition:
- Package trng_bridge_pkg: MODE_PULSE=0, MODE_STREAM=1, DROP_CNT_W=16, and a function computing level width from DEPTH.
- One sub-module: trng_sync_fifo (params W, DEPTH; ports wr_en, wr_data, rd_en, rd_data show-ahead, level, full, empty).
- The packer and read logic live in the top module.

Test Plan:
- IN_W=8, OUT_W=32, MODE=0: feed 8'h11,22,33,44, then toggle read_req once -> out_data 32'h44332211 with a single-cycle out_valid one cycle after the edge; level returns to 0.
- DEPTH=4, DROP_ON_FULL=1: write 6 packed words with no reads -> level 4, drop_cnt 2, words 1-4 read back in order; then clear_stats -> drop_cnt 0.
- DROP_ON_FULL=0, FIFO full: hold in_valid high -> in_ready low on the last slot until one pop, then the word enters; no data loss, drop_cnt 0.
- MODE=0, empty FIFO: read_req rising edge -> out_valid stays 0, underflow 1, out_data unchanged; holding read_req high produces only one edge.
- MODE=1: 16 back-to-back words with random out_ready stalls -> output sequence equals input, out_data stable during stalls, 1 word/cycle when out_ready stays high.
- Deassert enable after 2 of 4 slots, then reassert and feed 4 words -> only the last 4 form a word; rst mid-stream -> level 0, out_valid 0 next cycle.
